// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared constants, FSM encoding and address helpers for the
// HD44780 responder (instruction masks, DDRAM geometry, AC stepping rules).
package hd44780_pkg;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [5:0] LINE_LEN    = 6'd40;
    localparam int         DDRAM_DEPTH = 80;
    localparam logic [6:0] DDRAM_CELLS = 7'd80;
    localparam logic [7:0] FILL_CHAR   = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // An address is backed by RAM when its in-line offset is below the line length.
    function automatic logic ac_valid(input logic [6:0] addr);
        return (addr[5:0] < LINE_LEN);
    endfunction

    // Linear RAM index: line 1 starts right after the 40 cells of line 0.
    function automatic logic [6:0] ddram_index(input logic [6:0] addr);
        return (addr[6] ? {1'b0, LINE_LEN} : 7'd0) + {1'b0, addr[5:0]};
    endfunction

    // Step the address counter, wrapping between the ends of the two lines.
    function automatic logic [6:0] ac_step(input logic [6:0] addr, input logic inc);
        logic [6:0] res;
        if (inc) begin
            if (addr == LINE0_BASE + 7'd39)      res = LINE1_BASE;
            else if (addr == LINE1_BASE + 7'd39) res = LINE0_BASE;
            else                                 res = addr + 7'd1;
        end else begin
            if (addr == LINE0_BASE)              res = LINE1_BASE + 7'd39;
            else if (addr == LINE1_BASE)         res = LINE0_BASE + 7'd39;
            else                                 res = addr - 7'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hd44780_responder_if.sv
// hd44780_responder_if: host strobes (E/RW/RS) plus the stored mode bits
// (function set DL/N/F, entry mode I/D and S) observable by the host side.
interface hd44780_responder_if;
    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [2:0] func_bits;
    logic       entry_id;
    logic       entry_shift;

    modport master (output lcd_e, lcd_rw, lcd_rs,
                    input  func_bits, entry_id, entry_shift);
    modport slave  (input  lcd_e, lcd_rw, lcd_rs,
                    output func_bits, entry_id, entry_shift);
endinterface

// File: rtl/hd44780_ddram.sv
// hd44780_ddram: 80x8 display RAM, one write port (bus data or clear fill),
// a combinational bus read port and a registered scan read port.
module hd44780_ddram
    import hd44780_pkg::*;
#(
    parameter bit BUS_READ = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [6:0] wr_index,
    input  logic [7:0] wr_data,
    input  logic [6:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic [6:0] scan_addr,
    output logic [7:0] scan_data
);
    logic [7:0] mem_r [DDRAM_DEPTH];
    logic [7:0] scan_data_r;

    // Single write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem_r[wr_index] <= wr_data;
    end

    // Scan readback: one cycle latency, unbacked addresses read as zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 scan_data_r <= 8'h00;
        else if (ac_valid(scan_addr)) scan_data_r <= mem_r[ddram_index(scan_addr)];
        else                          scan_data_r <= 8'h00;
    end

    assign bus_data  = (BUS_READ && ac_valid(bus_addr)) ? mem_r[ddram_index(bus_addr)] : 8'h00;
    assign scan_data = scan_data_r;
endmodule

// File: rtl/hd44780_responder.sv
// hd44780_responder: device side of the HD44780 E/RW/RS/D[7:0] bus.
// Optional feature macro: HD44780_DATA_READ_EN (rs=1 reads return DDRAM[AC]
// and step AC); when undefined rs=1 reads return 0x00 with no side effect.
module hd44780_responder
    import hd44780_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 8,
    parameter int unsigned CLEAR_CYCLES = 96
) (
    input  logic                clock,
    input  logic                reset_n,
    hd44780_responder_if.slave  bus,
    inout  wire  [7:0]          lcd_data,
    input  logic [6:0]          scan_addr,
    output logic [7:0]          scan_data,
    output logic                busy,
    output logic                display_on,
    output logic                cursor_on,
    output logic                blink_on,
    output logic                protocol_err
);
`ifdef HD44780_DATA_READ_EN
    localparam bit DATA_READ = 1'b1;
`else
    localparam bit DATA_READ = 1'b0;
`endif
    localparam logic [6:0] BUSY_LOAD  = 7'(BUSY_CYCLES - 1);
    localparam logic [6:0] CLEAR_LOAD = 7'(CLEAR_CYCLES - 1);

    state_t     state_r, state_nx;
    logic [6:0] cnt_r, cnt_nx, fill_r, fill_nx;
    logic       e_q_r, cap_rs_r, cap_rw_r;
    logic [7:0] cap_data_r;
    logic [6:0] ac_r, ac_nx;
    logic       id_r, id_nx, s_r, s_nx;
    logic [2:0] func_r, func_nx, dcb_r, dcb_nx;
    logic       busy_r, perr_r;
    logic       commit_s, wr_commit_s, accept_s, is_clear_s, rd_step_s;
    logic       fill_we_s, data_we_s, drive_s;
    logic [7:0] ram_rd_s, rd_s;

    // A bus cycle completes on the first clock after E is seen low again.
    assign commit_s    = e_q_r & ~bus.lcd_e;
    assign wr_commit_s = commit_s & ~cap_rw_r;
    assign accept_s    = wr_commit_s & (state_r == ST_IDLE);
    assign is_clear_s  = accept_s & ~cap_rs_r & (cap_data_r == OP_CLEAR);
    assign rd_step_s   = DATA_READ & commit_s & cap_rw_r & cap_rs_r;
    assign fill_we_s   = (state_r == ST_CLEAR) && (fill_r < DDRAM_CELLS);
    assign data_we_s   = accept_s & cap_rs_r & ac_valid(ac_r);

    // Sample E and capture RS/RW/data on every cycle E is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_q_r      <= 1'b0;
            cap_rs_r   <= 1'b0;
            cap_rw_r   <= 1'b0;
            cap_data_r <= 8'h00;
        end else begin
            e_q_r <= bus.lcd_e;
            if (bus.lcd_e) begin
                cap_rs_r   <= bus.lcd_rs;
                cap_rw_r   <= bus.lcd_rw;
                cap_data_r <= lcd_data;
            end
        end
    end

    // FSM state, busy counter and clear fill pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 7'd0;
            fill_r  <= 7'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            fill_r  <= fill_nx;
            busy_r  <= (state_nx != ST_IDLE);
        end
    end

    // Next-state logic: accepted commits start a busy window, Clear also fills RAM.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        fill_nx  = fill_r;
        case (state_r)
            ST_IDLE: begin
                if (is_clear_s) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = CLEAR_LOAD;
                    fill_nx  = 7'd0;
                end else if (accept_s) begin
                    state_nx = ST_EXEC;
                    cnt_nx   = BUSY_LOAD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_EXEC, ST_CLEAR: begin
                if (fill_we_s) fill_nx = fill_r + 7'd1;
                else           fill_nx = fill_r;
                if (cnt_r == 7'd0) state_nx = ST_IDLE;
                else               cnt_nx   = cnt_r - 7'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Instruction / data decode; priority follows the highest set opcode bit.
    always_comb begin
        ac_nx   = ac_r;
        id_nx   = id_r;
        s_nx    = s_r;
        func_nx = func_r;
        dcb_nx  = dcb_r;
        if (accept_s && cap_rs_r) begin
            ac_nx = ac_step(ac_r, id_r);
        end else if (accept_s) begin
            if (|(cap_data_r & OP_DDRAM))        ac_nx = cap_data_r[6:0];
            else if (|(cap_data_r & OP_CGRAM))   ac_nx = ac_r;
            else if (|(cap_data_r & OP_FUNC))    func_nx = cap_data_r[4:2];
            else if (|(cap_data_r & OP_SHIFT)) begin
                if (cap_data_r[3]) ac_nx = ac_r;
                else               ac_nx = ac_step(ac_r, cap_data_r[2]);
            end
            else if (|(cap_data_r & OP_DISPLAY)) dcb_nx = cap_data_r[2:0];
            else if (|(cap_data_r & OP_ENTRY)) begin
                id_nx = cap_data_r[1];
                s_nx  = cap_data_r[0];
            end
            else if (|(cap_data_r & OP_HOME))    ac_nx = LINE0_BASE;
            else if (|(cap_data_r & OP_CLEAR)) begin
                ac_nx = LINE0_BASE;
                id_nx = 1'b1;
            end
            else ac_nx = ac_r;
        end else if (rd_step_s) begin
            ac_nx = ac_step(ac_r, id_r);
        end else begin
            ac_nx = ac_r;
        end
    end

    // Architectural registers: AC, entry mode, function set, display control, error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ac_r   <= 7'h00;
            id_r   <= 1'b1;
            s_r    <= 1'b0;
            func_r <= 3'b000;
            dcb_r  <= 3'b000;
            perr_r <= 1'b0;
        end else begin
            ac_r   <= ac_nx;
            id_r   <= id_nx;
            s_r    <= s_nx;
            func_r <= func_nx;
            dcb_r  <= dcb_nx;
            if (wr_commit_s && (state_r != ST_IDLE)) perr_r <= 1'b1;
        end
    end

    hd44780_ddram #(.BUS_READ(DATA_READ)) u_ddram (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (fill_we_s | data_we_s),
        .wr_index  (fill_we_s ? fill_r : ddram_index(ac_r)),
        .wr_data   (fill_we_s ? FILL_CHAR : cap_data_r),
        .bus_addr  (ac_r),
        .bus_data  (ram_rd_s),
        .scan_addr (scan_addr),
        .scan_data (scan_data)
    );

    // Read mux: status word for rs=0, RAM byte (or zero) for rs=1.
    always_comb begin
        if (bus.lcd_rs) rd_s = ram_rd_s;
        else            rd_s = {busy_r, ac_r};
    end

    assign drive_s  = bus.lcd_e & bus.lcd_rw;
    assign lcd_data = drive_s ? rd_s : 8'hzz;

    assign busy            = busy_r;
    assign display_on      = dcb_r[2];
    assign cursor_on       = dcb_r[1];
    assign blink_on        = dcb_r[0];
    assign protocol_err    = perr_r;
    assign bus.func_bits   = func_r;
    assign bus.entry_id    = id_r;
    assign bus.entry_shift = s_r;
endmodule

// File: tb/tb_hd44780_responder.sv
// tb_hd44780_responder: directed bench; expected values go through a
// scoreboard queue and are compared with immediate assertions.
module tb_hd44780_responder;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] host_data;
    logic       host_drive;
    logic [6:0] scan_addr;
    logic [7:0] scan_data;
    logic       busy, display_on, cursor_on, blink_on, protocol_err;
    wire  [7:0] lcd_data;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    hd44780_responder_if bus_if();

    assign lcd_data = host_drive ? host_data : 8'hzz;

    hd44780_responder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus_if.slave),
        .lcd_data     (lcd_data),
        .scan_addr    (scan_addr),
        .scan_data    (scan_data),
        .busy         (busy),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic sb_push(input string tag, input logic [7:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input logic [7:0] obs);
        logic [7:0] e;
        string      t;
        total_cnt++;
        if (exp_q.size() == 0) begin
            bad_cnt++;
            $error("FAIL sb_empty: observed=0x%02h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad_cnt++;
                $error("FAIL %s: observed=0x%02h expected=0x%02h", t, obs, e);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        bus_if.lcd_rs = rs;
        bus_if.lcd_rw = 1'b0;
        host_data     = d;
        host_drive    = 1'b1;
        bus_if.lcd_e  = 1'b1;
        @(posedge clock); #1;
        bus_if.lcd_e  = 1'b0;
        @(posedge clock); #1;
        host_drive    = 1'b0;
    endtask

    task automatic read_bus(input logic rs, input string tag, input logic [7:0] exp);
        bus_if.lcd_rs = rs;
        bus_if.lcd_rw = 1'b1;
        host_drive    = 1'b0;
        bus_if.lcd_e  = 1'b1;
        sb_push(tag, exp);
        #2;
        sb_check(lcd_data);
        @(posedge clock); #1;
        bus_if.lcd_e  = 1'b0;
        @(posedge clock); #1;
        bus_if.lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_timeout", {7'd0, busy}, 8'h00);
    endtask

    task automatic write_wait(input logic rs, input logic [7:0] d);
        bus_write(rs, d);
        wait_idle();
    endtask

    task automatic scan_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
        scan_addr = a;
        sb_push(tag, exp);
        @(posedge clock); #1;
        sb_check(scan_data);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] hello [5];
        int n;
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

        reset_n = 1'b0; bus_if.lcd_e = 1'b0; bus_if.lcd_rw = 1'b0; bus_if.lcd_rs = 1'b0;
        host_data = 8'h00; host_drive = 1'b0; scan_addr = 7'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy",  {7'd0, busy},         8'h00);
        check("rst_dcb",   {5'd0, display_on, cursor_on, blink_on}, 8'h00);
        check("rst_perr",  {7'd0, protocol_err}, 8'h00);
        check("rst_scan",  scan_data,            8'h00);
        check("rst_entry", {6'd0, bus_if.entry_id, bus_if.entry_shift}, 8'h02);
        reset_n = 1'b1;
        @(posedge clock); #1;
        read_bus(1'b0, "rst_status", 8'h00);

        // Function set, then hold a status read and watch the busy window.
        bus_write(1'b0, 8'h38);
        bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b1; bus_if.lcd_e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb_push("busy_poll", (i < 8) ? 8'h80 : 8'h00);
            #2;
            sb_check(lcd_data);
            @(posedge clock); #1;
        end
        bus_if.lcd_e = 1'b0;
        @(posedge clock); #1;
        bus_if.lcd_rw = 1'b0;
        check("func_bits", {5'd0, bus_if.func_bits}, 8'h06);

        // Clear: busy window length, then "Hello" at 0x04.
        bus_write(1'b0, 8'h01);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clock); #1;
        end
        check("clear_busy_len", n[7:0], 8'd96);
        write_wait(1'b0, 8'h84);
        for (int i = 0; i < 5; i++) write_wait(1'b1, hello[i]);
        for (int i = 0; i < 5; i++) scan_check("hello_scan", 7'(4 + i), hello[i]);
        scan_check("fill_first", 7'h00, 8'h20);
        scan_check("fill_l0end", 7'h27, 8'h20);
        scan_check("fill_last",  7'h67, 8'h20);
        read_bus(1'b0, "hello_ac", 8'h09);

        // Bus must be released once E is low, even with RW still high.
        bus_if.lcd_rw = 1'b1; host_data = 8'h00; host_drive = 1'b1;
        #2;
        check("bus_release", lcd_data, 8'h00);
        host_drive = 1'b0; bus_if.lcd_rw = 1'b0;
        @(posedge clock); #1;

        // Line wrap on increment.
        write_wait(1'b0, 8'hA7);
        write_wait(1'b1, 8'h41);
        write_wait(1'b1, 8'h42);
        read_bus(1'b0, "wrap_ac", 8'h41);
        scan_check("wrap_l0", 7'h27, 8'h41);
        scan_check("wrap_l1", 7'h40, 8'h42);

        // Unbacked address: byte dropped, AC still steps.
        write_wait(1'b0, 8'hA8);
        write_wait(1'b1, 8'h58);
        read_bus(1'b0, "gap_ac", 8'h29);
        scan_check("gap_scan", 7'h28, 8'h00);

        // Decrement mode and cursor shifts across line ends.
        write_wait(1'b0, 8'h04);
        check("entry_dec", {7'd0, bus_if.entry_id}, 8'h00);
        write_wait(1'b0, 8'hC0);
        write_wait(1'b1, 8'h51);
        read_bus(1'b0, "dec_ac", 8'h27);
        scan_check("dec_scan", 7'h40, 8'h51);
        write_wait(1'b0, 8'h14);
        read_bus(1'b0, "shift_r", 8'h40);
        write_wait(1'b0, 8'h10);
        read_bus(1'b0, "shift_l", 8'h27);
        write_wait(1'b0, 8'h02);
        read_bus(1'b0, "home", 8'h00);
        write_wait(1'b0, 8'h10);
        read_bus(1'b0, "shift_l0", 8'h67);
        write_wait(1'b0, 8'h06);

        // Display control.
        write_wait(1'b0, 8'h0E);
        check("dcb_0e", {5'd0, display_on, cursor_on, blink_on}, 8'h06);

        // Write while busy is dropped and latches the error flag.
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h5A);
        wait_idle();
        check("perr_set", {7'd0, protocol_err}, 8'h01);
        scan_check("perr_drop", 7'h00, 8'h20);
        read_bus(1'b0, "perr_ac", 8'h00);
        write_wait(1'b0, 8'h0F);
        check("perr_sticky", {7'd0, protocol_err}, 8'h01);
        check("dcb_0f", {5'd0, display_on, cursor_on, blink_on}, 8'h07);

        // Data read.
        write_wait(1'b0, 8'h84);
`ifdef HD44780_DATA_READ_EN
        read_bus(1'b1, "data_read", 8'h48);
        read_bus(1'b0, "data_read_ac", 8'h05);
`else
        read_bus(1'b1, "data_read", 8'h00);
        read_bus(1'b0, "data_read_ac", 8'h04);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
